// File: rtl/detector_pkg.sv
// rtl/detector_pkg.sv - shared constants and state encoding for the pattern detector
package detector_pkg;

    localparam int MAXLEN_DEF  = 8;
    localparam int LENW_DEF    = 4;
    localparam int CNTW_DEF    = 8;

    // Out of reset the block behaves as the classic fixed 110 detector
    localparam int RST_PATTERN = 6;
    localparam int RST_LEN     = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/detector_sequencer_if.sv
// rtl/detector_sequencer_if.sv - configuration handshake bundle for the detector
interface detector_sequencer_if
    import detector_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int LENW   = LENW_DEF,
    parameter int CNTW   = CNTW_DEF
) ();

    logic              cfg_valid;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LENW-1:0]   cfg_len;
    logic [CNTW-1:0]   cfg_target;
    logic              cfg_overlap;
    logic              cfg_err;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_overlap,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_overlap,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/pattern_matcher.sv
// rtl/pattern_matcher.sv - serial history, saturating valid-bit count and masked compare
module pattern_matcher
    import detector_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int LENW   = LENW_DEF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              aa,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [LENW-1:0]   len,
    output logic              hit
);

    logic [MAXLEN-1:0] hist_q;
    logic [MAXLEN-1:0] hist_nx;
    logic [MAXLEN-1:0] mask;
    logic [LENW-1:0]   vcnt_q;
    logic [LENW-1:0]   vcnt_nx;

    // Hit is judged on the post-shift view so the match lands on the completing edge
    always_comb begin
        hist_nx = {hist_q[MAXLEN-2:0], aa};
        vcnt_nx = (vcnt_q >= LENW'(MAXLEN)) ? LENW'(MAXLEN) : vcnt_q + 1'b1;
        mask    = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = (vcnt_nx >= len) && (((hist_nx ^ pattern) & mask) == '0);
    end

    // History and valid-bit count advance only while scanning; clear restarts both
    always_ff @(posedge clock) begin
        if (rst || clear) begin
            hist_q <= '0;
            vcnt_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_nx;
            vcnt_q <= vcnt_nx;
        end
    end

endmodule

// File: rtl/detector_sequencer.sv
// rtl/detector_sequencer.sv - programmable serial pattern detector with match counting
module detector_sequencer
    import detector_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int CNTW   = CNTW_DEF,
    parameter int LENW   = LENW_DEF
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 aa,
    input  logic                 start,
    input  logic                 abort,
    output logic                 ww,
    output logic [CNTW-1:0]      match_count,
    output logic                 busy,
    output logic                 done,
    detector_sequencer_if.slave  cfg
);

    state_t            state_q;
    state_t            state_nx;
    logic [MAXLEN-1:0] pat_q;
    logic [LENW-1:0]   len_q;
    logic [CNTW-1:0]   target_q;
    logic              overlap_q;
    logic              err_q;
    logic              run;
    logic              cfg_fire;
    logic              start_fire;
    logic              hit;
    logic              match;
    logic              target_hit;
    logic              len_bad;
    logic              m_clear;
    logic              m_shift;
    logic [CNTW-1:0]   count_inc;

    pattern_matcher #(.MAXLEN(MAXLEN), .LENW(LENW)) u_matcher (
        .clock    (clock),
        .rst      (rst),
        .clear    (m_clear),
        .shift_en (m_shift),
        .aa       (aa),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (hit)
    );

    // Qualify handshake, start and match events; abort suppresses a same-cycle match
    always_comb begin
        run        = (state_q == S_RUN);
        cfg_fire   = cfg.cfg_valid && !run;
        start_fire = !run && start && !cfg.cfg_valid && !err_q;
        match      = run && !abort && hit;
        count_inc  = match_count + 1'b1;
        target_hit = match && (target_q != '0) && (count_inc == target_q);
        len_bad    = (cfg.cfg_len == '0) || (cfg.cfg_len > LENW'(MAXLEN));
        m_shift    = run && !abort;
        m_clear    = start_fire || (match && !overlap_q);
    end

    // State register
    always_ff @(posedge clock) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nx;
    end

    // Next-state logic; an accepted config in DONE drops back to IDLE
    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE: if (start_fire) state_nx = S_RUN;
            S_RUN: begin
                if (abort)           state_nx = S_IDLE;
                else if (target_hit) state_nx = S_DONE;
            end
            S_DONE: begin
                if (cfg_fire)        state_nx = S_IDLE;
                else if (start_fire) state_nx = S_RUN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy          = (state_q == S_RUN);
        done          = (state_q == S_DONE);
        cfg.cfg_ready = (state_q != S_RUN);
        cfg.cfg_err   = err_q;
    end

    // Configuration registers; an illegal length is still taken but flagged
    always_ff @(posedge clock) begin
        if (rst) begin
            pat_q     <= MAXLEN'(RST_PATTERN);
            len_q     <= LENW'(RST_LEN);
            target_q  <= '0;
            overlap_q <= 1'b1;
            err_q     <= 1'b0;
        end else if (cfg_fire) begin
            pat_q     <= cfg.cfg_pattern;
            len_q     <= cfg.cfg_len;
            target_q  <= cfg.cfg_target;
            overlap_q <= cfg.cfg_overlap;
            err_q     <= len_bad;
        end
    end

    // Match counter and registered match pulse; free-running count saturates
    always_ff @(posedge clock) begin
        if (rst) begin
            match_count <= '0;
            ww          <= 1'b0;
        end else begin
            ww <= match;
            if (start_fire) begin
                match_count <= '0;
            end else if (match && !((target_q == '0) && (match_count == '1))) begin
                match_count <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_detector_sequencer.sv
// tb/tb_detector_sequencer.sv - scoreboard bench for detector_sequencer
module tb_detector_sequencer;
    import detector_pkg::*;

    localparam int MAXLEN = 8;
    localparam int LENW   = 4;
    localparam int CNTW   = 8;

    logic            clock = 1'b0;
    logic            rst;
    logic            aa;
    logic            start;
    logic            abort;
    logic            ww;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] match_count;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_q[$];
    logic obs_q[$];

    detector_sequencer_if #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW)) cfg_if ();

    detector_sequencer #(.MAXLEN(MAXLEN), .CNTW(CNTW), .LENW(LENW)) dut (
        .clock       (clock),
        .rst         (rst),
        .aa          (aa),
        .start       (start),
        .abort       (abort),
        .ww          (ww),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .cfg         (cfg_if)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cfg(input logic [MAXLEN-1:0] p, input logic [LENW-1:0] l,
                            input logic [CNTW-1:0] t, input logic ov, input logic with_start);
        cfg_if.cfg_pattern = p;
        cfg_if.cfg_len     = l;
        cfg_if.cfg_target  = t;
        cfg_if.cfg_overlap = ov;
        cfg_if.cfg_valid   = 1'b1;
        start              = with_start;
        step();
        cfg_if.cfg_valid   = 1'b0;
        start              = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drives bits MSB first; expected ww for each edge is queued, observed ww captured after it
    task automatic feed(input logic [15:0] bits, input logic [15:0] expv, input int n,
                        input logic abort_last);
        for (int i = n - 1; i >= 0; i--) begin
            aa    = bits[i];
            abort = abort_last && (i == 0);
            exp_q.push_back(expv[i]);
            step();
            obs_q.push_back(ww);
        end
        aa    = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (ww !== 1'b0) begin n_err++; $display("FAIL reset_ww got %b exp 0", ww); end
        n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", match_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_cmp++; if (cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err got %b exp 0", cfg_if.cfg_err); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_if.cfg_ready); end
    endtask

    task automatic test_default_110();
        int k = 0;
        logic e, o;
        do_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy_armed got %b exp 1", busy); end
        feed(16'b110110, 16'b001001, 6, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL t1_ww[%0d] got %b exp %b", k, o, e); end
            k++;
        end
        n_cmp++; if (match_count !== 8'd2) begin n_err++; $display("FAIL t1_count got %0d exp 2", match_count); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy got %b exp 1", busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_abort_busy got %b exp 0", busy); end
    endtask

    task automatic test_overlap_target();
        int k = 0;
        logic e, o;
        send_cfg(8'b1010, 4'd4, 8'd3, 1'b1, 1'b0);
        n_cmp++; if (cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL t2_cfg_err got %b exp 0", cfg_if.cfg_err); end
        do_start();
        feed(16'b10101010, 16'b00010101, 8, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL t2_ww[%0d] got %b exp %b", k, o, e); end
            k++;
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL t2_done got %b exp 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t2_busy got %b exp 0", busy); end
        n_cmp++; if (match_count !== 8'd3) begin n_err++; $display("FAIL t2_count got %0d exp 3", match_count); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL t2_cfg_ready got %b exp 1", cfg_if.cfg_ready); end
    endtask

    task automatic test_no_overlap();
        int k = 0;
        logic e, o;
        send_cfg(8'b1010, 4'd4, 8'd0, 1'b0, 1'b0);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL t3_done_cleared got %b exp 0", done); end
        do_start();
        feed(16'b10101010, 16'b00010001, 8, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL t3_ww[%0d] got %b exp %b", k, o, e); end
            k++;
        end
        n_cmp++; if (match_count !== 8'd2) begin n_err++; $display("FAIL t3_count got %0d exp 2", match_count); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t3_busy got %b exp 1", busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_bad_len();
        send_cfg(8'b110, 4'd0, 8'd0, 1'b1, 1'b0);
        n_cmp++; if (cfg_if.cfg_err !== 1'b1) begin n_err++; $display("FAIL t4_err_len0 got %b exp 1", cfg_if.cfg_err); end
        do_start();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t4_start_blocked got %b exp 0", busy); end
        send_cfg(8'b110, 4'd9, 8'd0, 1'b1, 1'b0);
        n_cmp++; if (cfg_if.cfg_err !== 1'b1) begin n_err++; $display("FAIL t4_err_len9 got %b exp 1", cfg_if.cfg_err); end
        send_cfg(8'b110, 4'd3, 8'd0, 1'b1, 1'b1);
        n_cmp++; if (cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL t4_err_len3 got %b exp 0", cfg_if.cfg_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t4_cfg_wins got %b exp 0", busy); end
        do_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t4_armed got %b exp 1", busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t4_abort got %b exp 0", busy); end
    endtask

    task automatic test_abort();
        int k = 0;
        logic e, o;
        do_start();
        feed(16'b110110, 16'b001000, 6, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL t5_ww[%0d] got %b exp %b", k, o, e); end
            k++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t5_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL t5_done got %b exp 0", done); end
        n_cmp++; if (match_count !== 8'd1) begin n_err++; $display("FAIL t5_count got %0d exp 1", match_count); end
        step();
        n_cmp++; if (ww !== 1'b0) begin n_err++; $display("FAIL t5_ww_after got %b exp 0", ww); end
        n_cmp++; if (match_count !== 8'd1) begin n_err++; $display("FAIL t5_count_held got %0d exp 1", match_count); end
    endtask

    task automatic test_cfg_in_run_and_rst();
        int k = 0;
        logic e, o;
        send_cfg(8'b1010, 4'd4, 8'd0, 1'b1, 1'b0);
        do_start();
        cfg_if.cfg_pattern = 8'b110;
        cfg_if.cfg_len     = 4'd3;
        cfg_if.cfg_target  = 8'd1;
        cfg_if.cfg_overlap = 1'b1;
        cfg_if.cfg_valid   = 1'b1;
        #1;
        n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL t6_ready_in_run got %b exp 0", cfg_if.cfg_ready); end
        feed(16'b1010, 16'b0001, 4, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL t6_ww_run[%0d] got %b exp %b", k, o, e); end
            k++;
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t6_busy got %b exp 1", busy); end
        n_cmp++; if (match_count !== 8'd1) begin n_err++; $display("FAIL t6_count got %0d exp 1", match_count); end
        rst = 1'b1;
        aa  = 1'b1;
        step();
        rst = 1'b0;
        aa  = 1'b0;
        n_cmp++; if (ww !== 1'b0) begin n_err++; $display("FAIL t6_rst_ww got %b exp 0", ww); end
        n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL t6_rst_count got %0d exp 0", match_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t6_rst_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL t6_rst_done got %b exp 0", done); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL t6_rst_ready got %b exp 1", cfg_if.cfg_ready); end
        n_cmp++; if (cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL t6_rst_err got %b exp 0", cfg_if.cfg_err); end
        do_start();
        k = 0;
        feed(16'b110, 16'b001, 3, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL t6_ww_110[%0d] got %b exp %b", k, o, e); end
            k++;
        end
        n_cmp++; if (match_count !== 8'd1) begin n_err++; $display("FAIL t6_count_110 got %0d exp 1", match_count); end
    endtask

    initial begin
        rst                = 1'b1;
        aa                 = 1'b0;
        start              = 1'b0;
        abort              = 1'b0;
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_pattern = '0;
        cfg_if.cfg_len     = '0;
        cfg_if.cfg_target  = '0;
        cfg_if.cfg_overlap = 1'b0;
        test_reset();
        test_default_110();
        test_overlap_target();
        test_no_overlap();
        test_bad_len();
        test_abort();
        test_cfg_in_run_and_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
